rst_seq_gen: RTL and testbench

Reset sequence generator for the DMA controller subsystem. It is the source end of the reset path: it produces the active-low block resets that each downstream clock domain's 2-flop reset synchronizer receives. On power-on, a software reset request or a watchdog expiry, it asserts every output reset together and holds them for a fixed time. It then releases them one at a time in index order, with a fixed gap between releases, so that dependent blocks come out of reset in a defined order.

---
 rtl/rst_seq_gen.sv | 124 ++++++++++++
 tb/tb_rst_seq_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset sequence generator: asserts all block resets together, holds them,
// then releases them one at a time in index order with a fixed gap.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (power-on sequence)
//   sw_rst_req  software reset request, level sampled each edge
//   wdt_expire  watchdog reset request, beats sw_rst_req
//   rst_n_out   active-low block resets, bit 0 released first
//   busy        high while a sequence is in progress
//   seq_done    one-cycle pulse on sequence completion
//   rst_cause   00 power-on, 01 software, 10 watchdog
module rst_seq_gen #(
  parameter int NUM_OUT        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic               wdt_expire,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               busy,
  output logic               seq_done,
  output logic [1:0]         rst_cause
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ?
                           HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int IW = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(NUM_OUT);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_IDLE    = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            req;
  logic [NUM_OUT-1:0] rel_mask;

  assign req = wdt_expire | sw_rst_req;

  // One-hot of the next output to release; OR-ing it in keeps
  // releases strictly in index order and never clears a bit.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == IW'(i)) rel_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ASSERT;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      seq_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else if (req) begin
      state     <= S_ASSERT;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      seq_done  <= 1'b0;
      rst_cause <= wdt_expire ? CAUSE_WDT : CAUSE_SW;
    end else begin
      seq_done <= 1'b0;
      case (state)
        S_ASSERT: begin
          if (cnt == HOLD_LAST) begin
            cnt          <= '0;
            idx          <= IW'(1);
            rst_n_out[0] <= 1'b1;
            state        <= S_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == STAG_LAST) begin
            cnt <= '0;
            if (idx < IDX_END) begin
              rst_n_out <= rst_n_out | rel_mask;
              idx       <= idx + IW'(1);
            end else begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          rst_n_out <= '1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_ASSERT;
          cnt       <= '0;
          idx       <= '0;
          rst_n_out <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: default instance plus a 1/1/1 instance,
// both checked against an elapsed-edge reference model.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  logic rst;
  logic sw_rst_req;
  logic wdt_expire;

  logic [2:0] a_out;
  logic       a_busy, a_done;
  logic [1:0] a_cause;
  logic [0:0] b_out;
  logic       b_busy, b_done;
  logic [1:0] b_cause;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_OUT(3), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)
  ) dut_a (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .wdt_expire(wdt_expire), .rst_n_out(a_out),
    .busy(a_busy), .seq_done(a_done), .rst_cause(a_cause)
  );

  rst_seq_gen #(
    .NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
  ) dut_b (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
    .wdt_expire(wdt_expire), .rst_n_out(b_out),
    .busy(b_busy), .seq_done(b_done), .rst_cause(b_cause)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int fails  = 0;

  // Expected outputs after an edge, given edges elapsed since the
  // sequence (re)started; t=0 is the edge that sampled rst/request.
  function automatic exp_t model(int t, int n, int h, int s,
                                 logic [1:0] c);
    exp_t e;
    e.out = '0;
    for (int i = 0; i < n; i++) e.out[i] = (t >= h + i * s);
    e.busy  = (t < h + n * s);
    e.done  = (t == h + n * s);
    e.cause = c;
    return e;
  endfunction

  int         t_el = 0;
  logic [1:0] cause_m = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      t_el = 0;
      cause_m = 2'b00;
    end else if (wdt_expire | sw_rst_req) begin
      t_el = 0;
      cause_m = wdt_expire ? 2'b10 : 2'b01;
    end else if (t_el < 100000) begin
      t_el = t_el + 1;
    end
    q_a.push_back(model(t_el, 3, 16, 4, cause_m));
    q_b.push_back(model(t_el, 1, 1, 1, cause_m));
  end

  int cyc_n = 0;

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    cyc_n++;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      g.out = 16'(a_out);
      g.busy = a_busy;
      g.done = a_done;
      g.cause = a_cause;
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL dut_a cyc %0d out=%b busy=%b done=%b cause=%b, expected out=%b busy=%b done=%b cause=%b",
                 cyc_n, g.out[2:0], g.busy, g.done, g.cause,
                 e.out[2:0], e.busy, e.done, e.cause);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      g.out = 16'(b_out);
      g.busy = b_busy;
      g.done = b_done;
      g.cause = b_cause;
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL dut_b cyc %0d out=%b busy=%b done=%b cause=%b, expected out=%b busy=%b done=%b cause=%b",
                 cyc_n, g.out[0], g.busy, g.done, g.cause,
                 e.out[0], e.busy, e.done, e.cause);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic w,
                       input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      sw_rst_req = s;
      wdt_expire = w;
    end
  endtask

  initial begin
    rst = 1'b1;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    drive(1, 0, 0, 5);
    drive(0, 0, 0, 32);
    // software pulse from idle
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 32);
    // simultaneous requests: watchdog wins
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 32);
    // abort at edge 21 while outputs read 011
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 20);
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 32);
    // held request, then rst at edge 22
    drive(0, 1, 0, 40);
    drive(0, 0, 0, 21);
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 32);
    // watchdog only
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 32);
    // random requests with occasional rst
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) < 1) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 2) ? 1'b1 : 1'b0, 1);
    end
    drive(0, 0, 0, 32);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
